// File: rtl/wc_tile_sched.sv
// Tile scheduler for the Winograd convolution datapath: issues input tiles only
// when result space is reserved, captures results LAT cycles later into a FIFO.
module wc_tile_sched #(
    parameter int DW_IN      = 70,
    parameter int DW_OUT     = 40,
    parameter int LAT        = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_tiles,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW_IN-1:0]  in_data,
    output logic [DW_IN-1:0]  wc_d,
    input  logic [DW_OUT-1:0] wc_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW_OUT-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + LAT + 1) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   n_reg, n_next;
    logic [CNT_W-1:0]   issued_reg, issued_next, issued_inc;
    logic [CNT_W-1:0]   popped_reg, popped_next, popped_inc;
    logic [LAT:1]       vld_sr_reg, vld_sr_next;
    logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [PW:0]        count_reg, count_next;
    logic [DW_IN-1:0]   wc_d_reg, wc_d_next;
    logic [DW_OUT-1:0]  head_reg, head_next;
    logic               done_reg, done_next;

    logic [DW_OUT-1:0]  fifo_mem [FIFO_DEPTH];

    logic [OW-1:0]      inflight;
    logic [OW-1:0]      occupancy;
    logic               accept;
    logic               push;
    logic               pop;

    // Reserved space covers both queued results and tiles still inside WC.
    always_comb begin
        inflight = '0;
        for (int i = 1; i <= LAT; i++) begin
            inflight = inflight + OW'(vld_sr_reg[i]);
        end
    end

    assign occupancy  = OW'(count_reg) + inflight;
    assign in_ready   = (state_reg == RUN) && (occupancy < OW'(FIFO_DEPTH))
                        && (issued_reg < n_reg);
    assign accept     = in_ready && in_valid;
    assign push       = vld_sr_reg[LAT];
    assign pop        = out_ready && (count_reg != '0);

    assign issued_inc = issued_reg + CNT_W'(1);
    assign popped_inc = popped_reg + CNT_W'(1);

    assign out_valid  = (count_reg != '0);
    assign out_data   = head_reg;
    assign wc_d       = wc_d_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;

    assign vld_sr_next[1] = accept;
    genvar gi;
    generate
        for (gi = 2; gi <= LAT; gi++) begin : g_vld_shift
            assign vld_sr_next[gi] = vld_sr_reg[gi-1];
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        n_next      = n_reg;
        issued_next = issued_reg;
        popped_next = popped_reg;
        done_next   = 1'b0;

        if (pop && (popped_reg != n_reg)) begin
            popped_next = popped_inc;
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (n_tiles != '0) begin
                        state_next  = RUN;
                        n_next      = n_tiles;
                        issued_next = '0;
                        popped_next = '0;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    issued_next = issued_inc;
                    if (issued_inc == n_reg) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && (popped_inc == n_reg)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wc_d_next   = accept ? in_data : wc_d_reg;
        wr_ptr_next = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
        rd_ptr_next = pop  ? rd_ptr_reg + PW'(1) : rd_ptr_reg;
        count_next  = count_reg;
        if (push && !pop) begin
            count_next = count_reg + (PW+1)'(1);
        end else if (!push && pop) begin
            count_next = count_reg - (PW+1)'(1);
        end

        // Head register: bypass the incoming result when it becomes the head.
        head_next = '0;
        if (count_next != '0) begin
            if (push && (rd_ptr_next == wr_ptr_reg)) begin
                head_next = wc_z;
            end else begin
                head_next = fifo_mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            fifo_mem[wr_ptr_reg] <= wc_z;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            n_reg      <= '0;
            issued_reg <= '0;
            popped_reg <= '0;
            vld_sr_reg <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            wc_d_reg   <= '0;
            head_reg   <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            n_reg      <= n_next;
            issued_reg <= issued_next;
            popped_reg <= popped_next;
            vld_sr_reg <= vld_sr_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            wc_d_reg   <= wc_d_next;
            head_reg   <= head_next;
            done_reg   <= done_next;
        end
    end

endmodule

// File: tb/tb_wc_tile_sched.sv
// Self-checking bench for wc_tile_sched: hand vectors plus a job-level reference
// model that tracks accept times and expected result order.
module tb_wc_tile_sched;

    localparam int DW_IN  = 70;
    localparam int DW_OUT = 40;
    localparam int LAT    = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  n_tiles;
    logic              in_valid;
    logic              in_ready;
    logic [DW_IN-1:0]  in_data;
    logic [DW_IN-1:0]  wc_d;
    logic [DW_OUT-1:0] wc_z;
    logic              out_valid;
    logic              out_ready;
    logic [DW_OUT-1:0] out_data;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    wc_tile_sched #(
        .DW_IN(DW_IN), .DW_OUT(DW_OUT), .LAT(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .n_tiles(n_tiles),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .wc_d(wc_d), .wc_z(wc_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    // WC stub: low 40 bits of wc_d, visible LAT cycles after the wc_d update.
    logic [DW_OUT-1:0] stub_sr [1:LAT-1];
    always_ff @(posedge clk) begin
        stub_sr[1] <= wc_d[DW_OUT-1:0];
        for (int i = 2; i < LAT; i++) stub_sr[i] <= stub_sr[i-1];
    end
    assign wc_z = stub_sr[LAT-1];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    bit               m_active = 0;
    int               m_n = 0, m_acc = 0, m_pop = 0;
    bit               m_done = 0;
    logic [DW_IN-1:0] m_wc_d = '0;
    int               q_time[$];
    logic [DW_IN-1:0] q_data[$];
    bit               exp_in_ready = 0, exp_out_valid = 0;

    int dut_acc_cnt = 0, dut_pop_cnt = 0, dut_done_cnt = 0;

    typedef struct {
        logic             start;
        logic [CNT_W-1:0] n;
        logic             iv;
        logic [DW_IN-1:0] d;
        logic             ordy;
        logic             e_ir;
        logic             e_ov;
        logic [DW_OUT-1:0] e_od;
        logic             e_busy;
        logic             e_done;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic st, int n, logic iv, logic [DW_IN-1:0] d, logic ordy,
                                logic eir, logic eov, logic [DW_OUT-1:0] eod, logic eb, logic ed);
        vec_t v;
        v.start = st; v.n = CNT_W'(n); v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_busy = eb; v.e_done = ed;
        return v;
    endfunction

    function automatic logic [DW_IN-1:0] rnd();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW_IN-1:0];
    endfunction

    task automatic chk(input string name, input logic [DW_IN-1:0] act, input logic [DW_IN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, DW_IN'(act), DW_IN'(exp));
    endtask

    // One clock edge: model update from pre-edge handshakes, then compare.
    task automatic step();
        bit acc_now, pop_now;
        int matured;
        acc_now = in_valid && exp_in_ready;
        pop_now = out_ready && exp_out_valid;
        if (in_valid && in_ready) dut_acc_cnt++;
        if (out_valid && out_ready) dut_pop_cnt++;
        @(posedge clk);
        cyc++;
        if (!rst) begin
            m_active = 0; m_acc = 0; m_pop = 0; m_done = 0; m_wc_d = '0;
            q_time.delete(); q_data.delete();
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (start) begin
                    if (n_tiles != '0) begin
                        m_active = 1; m_n = int'(n_tiles); m_acc = 0; m_pop = 0;
                        q_time.delete(); q_data.delete();
                    end else begin
                        m_done = 1;
                    end
                end
            end else begin
                if (acc_now) begin
                    q_time.push_back(cyc);
                    q_data.push_back(in_data);
                    m_acc++;
                    m_wc_d = in_data;
                end
                if (pop_now) begin
                    $display("pop %0d data %h", m_pop, q_data[m_pop][DW_OUT-1:0]);
                    m_pop++;
                    if (m_pop == m_n) begin
                        m_active = 0;
                        m_done = 1;
                    end
                end
            end
        end
        #1;
        matured = 0;
        foreach (q_time[i]) if (q_time[i] + LAT <= cyc) matured++;
        exp_in_ready  = m_active && (m_acc < m_n) && ((m_acc - m_pop) < DEPTH);
        exp_out_valid = (matured > m_pop);
        chk1("in_ready", in_ready, exp_in_ready);
        chk1("out_valid", out_valid, exp_out_valid);
        if (exp_out_valid) chk("out_data", DW_IN'(out_data), DW_IN'(q_data[m_pop][DW_OUT-1:0]));
        if (!rst) chk("out_data_rst", DW_IN'(out_data), '0);
        chk1("busy", busy, m_active);
        chk1("done", done, m_done);
        chk("wc_d", wc_d, m_wc_d);
        if (done) dut_done_cnt++;
    endtask

    initial begin
        int a0, p0, d0;

        tbl[0]  = mk(1, 3, 1, 70'h11, 1,  1, 0, 40'h0,  1, 0);
        tbl[1]  = mk(0, 0, 1, 70'h11, 1,  1, 0, 40'h0,  1, 0);
        tbl[2]  = mk(0, 0, 1, 70'h22, 1,  1, 0, 40'h0,  1, 0);
        tbl[3]  = mk(0, 0, 1, 70'h33, 1,  0, 0, 40'h0,  1, 0);
        tbl[4]  = mk(0, 0, 0, 70'h0,  1,  0, 0, 40'h0,  1, 0);
        tbl[5]  = mk(0, 0, 0, 70'h0,  1,  0, 1, 40'h11, 1, 0);
        tbl[6]  = mk(0, 0, 0, 70'h0,  1,  0, 1, 40'h22, 1, 0);
        tbl[7]  = mk(0, 0, 0, 70'h0,  1,  0, 1, 40'h33, 1, 0);
        tbl[8]  = mk(0, 0, 0, 70'h0,  1,  0, 0, 40'h0,  0, 1);
        tbl[9]  = mk(0, 0, 0, 70'h0,  1,  0, 0, 40'h0,  0, 0);
        tbl[10] = mk(1, 0, 0, 70'h0,  1,  0, 0, 40'h0,  0, 1);
        tbl[11] = mk(0, 0, 0, 70'h0,  1,  0, 0, 40'h0,  0, 0);

        rst = 0; start = 0; n_tiles = '0; in_valid = 0; in_data = '0; out_ready = 0;

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            rst = 0; start = 1'($urandom); n_tiles = CNT_W'($urandom);
            in_valid = 1'($urandom); in_data = rnd(); out_ready = 1'($urandom);
            step();
        end
        rst = 1; start = 0; in_valid = 0; out_ready = 0;
        step();

        // Short job and zero-length job, cycle by cycle.
        for (int i = 0; i < 12; i++) begin
            start = tbl[i].start; n_tiles = tbl[i].n; in_valid = tbl[i].iv;
            in_data = tbl[i].d; out_ready = tbl[i].ordy;
            step();
            chk1("tbl_in_ready", in_ready, tbl[i].e_ir);
            chk1("tbl_out_valid", out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) chk("tbl_out_data", DW_IN'(out_data), DW_IN'(tbl[i].e_od));
            chk1("tbl_busy", busy, tbl[i].e_busy);
            chk1("tbl_done", done, tbl[i].e_done);
        end
        start = 0; in_valid = 0;

        // Backpressure: FIFO_DEPTH tiles only, then release.
        start = 1; n_tiles = 20; in_valid = 1; in_data = rnd(); out_ready = 0;
        step();
        start = 0;
        a0 = dut_acc_cnt; p0 = dut_pop_cnt; d0 = dut_done_cnt;
        repeat (30) begin in_data = rnd(); step(); end
        chk("t3_accepted_while_blocked", DW_IN'(dut_acc_cnt - a0), DW_IN'(DEPTH));
        chk1("t3_in_ready_blocked", in_ready, 1'b0);
        out_ready = 1;
        for (int i = 0; i < 300 && dut_done_cnt == d0; i++) begin in_data = rnd(); step(); end
        chk("t3_done_count", DW_IN'(dut_done_cnt - d0), DW_IN'(1));
        chk("t3_pops", DW_IN'(dut_pop_cnt - p0), DW_IN'(20));
        chk("t3_accepts", DW_IN'(dut_acc_cnt - a0), DW_IN'(20));
        in_valid = 0;

        // start re-pulsed mid-job is ignored.
        start = 1; n_tiles = 5; in_valid = 1; in_data = rnd(); out_ready = 1;
        step();
        start = 0;
        p0 = dut_pop_cnt; d0 = dut_done_cnt;
        in_data = rnd(); step();
        in_data = rnd(); step();
        start = 1; n_tiles = 9; in_data = rnd(); step();
        start = 0;
        for (int i = 0; i < 100 && dut_done_cnt == d0; i++) begin in_data = rnd(); step(); end
        chk("t5_done_count", DW_IN'(dut_done_cnt - d0), DW_IN'(1));
        chk("t5_pops", DW_IN'(dut_pop_cnt - p0), DW_IN'(5));

        // Reset mid-job after two accepted tiles.
        start = 1; n_tiles = 4; in_valid = 1; in_data = rnd();
        step();
        start = 0;
        a0 = dut_acc_cnt;
        for (int i = 0; i < 20 && (dut_acc_cnt - a0) < 2; i++) begin in_data = rnd(); step(); end
        rst = 0; step();
        rst = 1; in_valid = 0;
        chk1("t5_rst_in_ready", in_ready, 1'b0);
        chk1("t5_rst_out_valid", out_valid, 1'b0);
        chk1("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_wc_d", wc_d, '0);
        repeat (LAT + 2) step();
        chk1("t5_flushed_out_valid", out_valid, 1'b0);
        start = 1; n_tiles = 2; in_valid = 1; in_data = rnd();
        step();
        start = 0;
        p0 = dut_pop_cnt; d0 = dut_done_cnt;
        for (int i = 0; i < 50 && dut_done_cnt == d0; i++) begin in_data = rnd(); step(); end
        chk("t5_fresh_done", DW_IN'(dut_done_cnt - d0), DW_IN'(1));
        chk("t5_fresh_pops", DW_IN'(dut_pop_cnt - p0), DW_IN'(2));

        // Random gaps on both sides.
        start = 1; n_tiles = 100; in_valid = 0; out_ready = 0;
        step();
        start = 0;
        a0 = dut_acc_cnt; p0 = dut_pop_cnt; d0 = dut_done_cnt;
        for (int i = 0; i < 3000 && dut_done_cnt == d0; i++) begin
            in_valid = 1'($urandom); in_data = rnd(); out_ready = 1'($urandom);
            step();
            if (((dut_acc_cnt - a0) - (dut_pop_cnt - p0)) > DEPTH)
                chk("t6_occupancy", DW_IN'((dut_acc_cnt - a0) - (dut_pop_cnt - p0)), DW_IN'(DEPTH));
        end
        in_valid = 0; out_ready = 1;
        repeat (5) step();
        chk("t6_done_count", DW_IN'(dut_done_cnt - d0), DW_IN'(1));
        chk("t6_pops", DW_IN'(dut_pop_cnt - p0), DW_IN'(100));
        chk("t6_accepts", DW_IN'(dut_acc_cnt - a0), DW_IN'(100));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
